instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Sequencing decoder for the 6502-style CPU datapath. It accepts opcode and operand bytes one at a time from the fetcher over a ready/request handshake. For each instruction it produces a single-cycle execute step: register write enables, mux831 source selects, fan138 target selects, a memory write strobe and an immediate/zero-page value. It sits between the fetcher and the register/mux/fan routing fabric and runs on the phi1 phase.

## Interface
- REG_WIDTH, 8, data/opcode/immediate width
- WE_WIDTH, 7, write-enable vector width; bit map: PC=0, SP=1, ADD=2, X=3, Y=4, STAT=5, DOUT=6
- clk  in  1  phi1 clock; one clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- instruction_in  in  REG_WIDTH  byte from fetcher
- instruction_ready  in  1  instruction_in valid this cycle
- opp  out  REG_WIDTH  latched opcode of current instruction
- we  out  WE_WIDTH  register write enables; bit 6 (DOUT) driven 0, memory write uses read_write
- read_write  out  1  memory write strobe (1 = write d_to_mem to imm_addr)
- source_selector_0 / target_selector_0  out  3  path-0 mux831 source / fan138 target
- source_selector_1 / target_selector_1  out  3  path-1 selects (reserved)
- imm_addr  out  REG_WIDTH  latched operand byte (immediate value or zero-page address)
- get_next  out  1  request next byte from fetcher

## Operation
- Source codes: 0 PC, 1 ADD(A), 2 X, 3 Y, 4 IMM, 5 MEM, 6 zero, 7 FETCH.
- Target codes: 0 PC, 1 ADD, 2 X, 3 Y, 4 none, 5 MEM, 6 ALU, 7 FETCH.
- Idle outputs (all states except EXEC): we=0, read_write=0, source_selector_0/1=6, target_selector_0/1=4.
- Path 1 is always idle (6/4) in this revision.
- FSM states: REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, EXEC.
  - REQ_OP: get_next=1 for one cycle, then go to WAIT_OP.
  - WAIT_OP: hold until instruction_ready=1. On that edge latch opp=instruction_in. Two-byte opcode → REQ_ARG; otherwise → EXEC.
  - REQ_ARG: get_next=1 for one cycle, then go to WAIT_ARG.
  - WAIT_ARG: hold until instruction_ready=1. On that edge latch imm_addr=instruction_in, then go to EXEC.
  - EXEC: drive decoded outputs for exactly one cycle, then go to REQ_OP.
- get_next is high only in REQ_OP and REQ_ARG.
- Decode table, EXEC outputs as src→tgt, write-enable:
  - A9 LDA #: 4→1, we[2].
  - A2 LDX #: 4→2, we[3].
  - A0 LDY #: 4→3, we[4].
  - A5 LDA zpg: 5→1, we[2]; imm_addr presented as read address.
  - 85 STA zpg: 1→5, read_write=1.
  - 86 STX zpg: 2→5, read_write=1.
  - 84 STY zpg: 3→5, read_write=1.
  - AA TAX: 1→2, we[3].
  - A8 TAY: 1→3, we[4].
  - 8A TXA: 2→1, we[2].
  - 98 TYA: 3→1, we[2].
  - EA NOP: idle outputs.
- Two-byte opcodes: A9, A2, A0, A5, 85, 86, 84. All others are one-byte.
- Any unlisted opcode, including 00, is a one-byte NOP: EXEC with idle outputs.
- imm_addr holds its value until the next operand is latched. One-byte instructions do not modify it.
- instruction_ready high outside WAIT_OP/WAIT_ARG is ignored.

## Timing
- Reset (reset_n=0 at rising edge) sets state=REQ_OP, opp=0, imm_addr=0.
- All outputs are Moore outputs of state and latched registers. During reset: get_next=0, plus idle outputs.
- First rising edge with reset_n=1 enters REQ_OP behaviour: get_next=1 in the following cycle.
- Reset asserted mid-instruction aborts it; no EXEC outputs are produced.
- Latency from REQ_OP entry to EXEC:
  - two-byte instruction: 4 cycles + fetcher wait cycles;
  - one-byte instruction: 2 cycles + fetcher wait cycles.
- EXEC lasts exactly one cycle. Registers and memory capture on the phi2 edge following it.
- Back-to-back: REQ_OP follows EXEC immediately. Throughput with zero-wait fetcher: 5 cycles for two-byte, 3 cycles for one-byte.
- instruction_ready and get_next high in the same cycle is legal. The byte is accepted only in a WAIT state.

## Test plan
- Reset, release → get_next=1 for one cycle; we=0, selectors 6/4, opp=00, imm_addr=00.
- Feed A9 then 04, ready one cycle after each request → one EXEC cycle with src0=4, tgt0=1, we=0000100, imm_addr=04, read_write=0.
- Feed 85 then 02 → EXEC with src0=1, tgt0=5, read_write=1, imm_addr=02, we=0.
- Feed AA → no REQ_ARG; EXEC with src0=1, tgt0=2, we=0001000; imm_addr unchanged from the prior operand.
- Feed 00 and FF → treated as one-byte NOP with idle EXEC outputs; get_next re-asserted the cycle after.
- Hold instruction_ready low for 5 cycles in WAIT_ARG, then assert reset_n=0 → no EXEC pulse; state returns to REQ_OP; opp=imm_addr=00.

Source files
------------

// File: rtl/instruction_decoder_if.sv
`default_nettype none
// ============================================================================
// instruction_decoder_if
// Fetcher-side byte handshake plus the decoded execute-step routing bundle.
// Revision: 1.0
// ============================================================================
interface instruction_decoder_if #(
   parameter int REG_WIDTH = 8,
   parameter int WE_WIDTH  = 7
);
   logic [REG_WIDTH-1:0] instruction_in;
   logic                 instruction_ready;
   logic [REG_WIDTH-1:0] opp;
   logic [WE_WIDTH-1:0]  we;
   logic                 read_write;
   logic [2:0]           source_selector_0;
   logic [2:0]           target_selector_0;
   logic [2:0]           source_selector_1;
   logic [2:0]           target_selector_1;
   logic [REG_WIDTH-1:0] imm_addr;
   logic                 get_next;

   modport master (
      output instruction_in, instruction_ready,
      input  opp, we, read_write, source_selector_0, target_selector_0,
             source_selector_1, target_selector_1, imm_addr, get_next
   );

   modport slave (
      input  instruction_in, instruction_ready,
      output opp, we, read_write, source_selector_0, target_selector_0,
             source_selector_1, target_selector_1, imm_addr, get_next
   );
endinterface
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// instruction_decoder
// Fetches opcode/operand bytes and emits a one-cycle execute routing step.
// Revision: 1.0
// ============================================================================
module instruction_decoder #(
   parameter int REG_WIDTH = 8,
   parameter int WE_WIDTH  = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   instruction_decoder_if.slave  bus
);

   typedef enum logic [2:0] {
      S_REQ_OP   = 3'd0,
      S_WAIT_OP  = 3'd1,
      S_REQ_ARG  = 3'd2,
      S_WAIT_ARG = 3'd3,
      S_EXEC     = 3'd4
   } state_t;

   localparam logic [2:0] c_SRC_ADD  = 3'd1;
   localparam logic [2:0] c_SRC_X    = 3'd2;
   localparam logic [2:0] c_SRC_Y    = 3'd3;
   localparam logic [2:0] c_SRC_IMM  = 3'd4;
   localparam logic [2:0] c_SRC_MEM  = 3'd5;
   localparam logic [2:0] c_SRC_ZERO = 3'd6;

   localparam logic [2:0] c_TGT_ADD  = 3'd1;
   localparam logic [2:0] c_TGT_X    = 3'd2;
   localparam logic [2:0] c_TGT_Y    = 3'd3;
   localparam logic [2:0] c_TGT_NONE = 3'd4;
   localparam logic [2:0] c_TGT_MEM  = 3'd5;

   localparam int c_WE_ADD = 2;
   localparam int c_WE_X   = 3;
   localparam int c_WE_Y   = 4;

   localparam logic [REG_WIDTH-1:0] c_LDA_IMM = REG_WIDTH'(8'hA9);
   localparam logic [REG_WIDTH-1:0] c_LDX_IMM = REG_WIDTH'(8'hA2);
   localparam logic [REG_WIDTH-1:0] c_LDY_IMM = REG_WIDTH'(8'hA0);
   localparam logic [REG_WIDTH-1:0] c_LDA_ZPG = REG_WIDTH'(8'hA5);
   localparam logic [REG_WIDTH-1:0] c_STA_ZPG = REG_WIDTH'(8'h85);
   localparam logic [REG_WIDTH-1:0] c_STX_ZPG = REG_WIDTH'(8'h86);
   localparam logic [REG_WIDTH-1:0] c_STY_ZPG = REG_WIDTH'(8'h84);
   localparam logic [REG_WIDTH-1:0] c_TAX     = REG_WIDTH'(8'hAA);
   localparam logic [REG_WIDTH-1:0] c_TAY     = REG_WIDTH'(8'hA8);
   localparam logic [REG_WIDTH-1:0] c_TXA     = REG_WIDTH'(8'h8A);
   localparam logic [REG_WIDTH-1:0] c_TYA     = REG_WIDTH'(8'h98);

   state_t               r_state;
   state_t               w_next_state;
   logic                 r_started;
   logic [REG_WIDTH-1:0] r_opp;
   logic [REG_WIDTH-1:0] r_imm;
   logic                 w_two_byte;
   logic [WE_WIDTH-1:0]  w_we;
   logic                 w_read_write;
   logic [2:0]           w_src0;
   logic [2:0]           w_tgt0;

   always_comb begin
      w_two_byte = 1'b0;
      case (bus.instruction_in)
         c_LDA_IMM, c_LDX_IMM, c_LDY_IMM, c_LDA_ZPG,
         c_STA_ZPG, c_STX_ZPG, c_STY_ZPG: w_two_byte = 1'b1;
         default:                         w_two_byte = 1'b0;
      endcase
   end

   // r_started holds REQ_OP silent for the first cycle after reset release.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_REQ_OP;
         r_started <= 1'b0;
         r_opp     <= '0;
         r_imm     <= '0;
      end else begin
         r_state   <= w_next_state;
         r_started <= 1'b1;
         if (r_state == S_WAIT_OP && bus.instruction_ready)
            r_opp <= bus.instruction_in;
         if (r_state == S_WAIT_ARG && bus.instruction_ready)
            r_imm <= bus.instruction_in;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_REQ_OP:   if (r_started) w_next_state = S_WAIT_OP;
         S_WAIT_OP:  if (bus.instruction_ready)
                        w_next_state = w_two_byte ? S_REQ_ARG : S_EXEC;
         S_REQ_ARG:  w_next_state = S_WAIT_ARG;
         S_WAIT_ARG: if (bus.instruction_ready) w_next_state = S_EXEC;
         S_EXEC:     w_next_state = S_REQ_OP;
         default:    w_next_state = S_REQ_OP;
      endcase
   end

   always_comb begin
      w_we         = '0;
      w_read_write = 1'b0;
      w_src0       = c_SRC_ZERO;
      w_tgt0       = c_TGT_NONE;
      if (r_state == S_EXEC) begin
         case (r_opp)
            c_LDA_IMM: begin w_src0 = c_SRC_IMM; w_tgt0 = c_TGT_ADD; w_we[c_WE_ADD] = 1'b1; end
            c_LDX_IMM: begin w_src0 = c_SRC_IMM; w_tgt0 = c_TGT_X;   w_we[c_WE_X]   = 1'b1; end
            c_LDY_IMM: begin w_src0 = c_SRC_IMM; w_tgt0 = c_TGT_Y;   w_we[c_WE_Y]   = 1'b1; end
            c_LDA_ZPG: begin w_src0 = c_SRC_MEM; w_tgt0 = c_TGT_ADD; w_we[c_WE_ADD] = 1'b1; end
            c_STA_ZPG: begin w_src0 = c_SRC_ADD; w_tgt0 = c_TGT_MEM; w_read_write   = 1'b1; end
            c_STX_ZPG: begin w_src0 = c_SRC_X;   w_tgt0 = c_TGT_MEM; w_read_write   = 1'b1; end
            c_STY_ZPG: begin w_src0 = c_SRC_Y;   w_tgt0 = c_TGT_MEM; w_read_write   = 1'b1; end
            c_TAX:     begin w_src0 = c_SRC_ADD; w_tgt0 = c_TGT_X;   w_we[c_WE_X]   = 1'b1; end
            c_TAY:     begin w_src0 = c_SRC_ADD; w_tgt0 = c_TGT_Y;   w_we[c_WE_Y]   = 1'b1; end
            c_TXA:     begin w_src0 = c_SRC_X;   w_tgt0 = c_TGT_ADD; w_we[c_WE_ADD] = 1'b1; end
            c_TYA:     begin w_src0 = c_SRC_Y;   w_tgt0 = c_TGT_ADD; w_we[c_WE_ADD] = 1'b1; end
            default:   begin w_src0 = c_SRC_ZERO; w_tgt0 = c_TGT_NONE; end
         endcase
      end
   end

   assign bus.opp               = r_opp;
   assign bus.imm_addr          = r_imm;
   assign bus.we                = w_we;
   assign bus.read_write        = w_read_write;
   assign bus.source_selector_0 = w_src0;
   assign bus.target_selector_0 = w_tgt0;
   assign bus.source_selector_1 = c_SRC_ZERO;
   assign bus.target_selector_1 = c_TGT_NONE;
   assign bus.get_next          = (r_state == S_REQ_OP && r_started) || (r_state == S_REQ_ARG);

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// tb_instruction_decoder
// Directed fetcher model with an expected-execute-step scoreboard.
// Revision: 1.0
// ============================================================================
module tb_instruction_decoder;

   typedef struct packed {
      logic [7:0] opp;
      logic [7:0] imm;
      logic [2:0] src;
      logic [2:0] tgt;
      logic [6:0] we;
      logic       rw;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   exp_t sb[$];
   logic [7:0] m_imm;

   instruction_decoder_if #(.REG_WIDTH(8), .WE_WIDTH(7)) bus ();

   instruction_decoder #(.REG_WIDTH(8), .WE_WIDTH(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_two(input logic [7:0] op);
      return (op == 8'hA9 || op == 8'hA2 || op == 8'hA0 || op == 8'hA5 ||
              op == 8'h85 || op == 8'h86 || op == 8'h84);
   endfunction

   function automatic exp_t model(input logic [7:0] op, input logic [7:0] imm);
      exp_t e;
      e.opp = op; e.imm = imm; e.src = 3'd6; e.tgt = 3'd4; e.we = 7'b0; e.rw = 1'b0;
      case (op)
         8'hA9: begin e.src = 3'd4; e.tgt = 3'd1; e.we = 7'b0000100; end
         8'hA2: begin e.src = 3'd4; e.tgt = 3'd2; e.we = 7'b0001000; end
         8'hA0: begin e.src = 3'd4; e.tgt = 3'd3; e.we = 7'b0010000; end
         8'hA5: begin e.src = 3'd5; e.tgt = 3'd1; e.we = 7'b0000100; end
         8'h85: begin e.src = 3'd1; e.tgt = 3'd5; e.rw = 1'b1; end
         8'h86: begin e.src = 3'd2; e.tgt = 3'd5; e.rw = 1'b1; end
         8'h84: begin e.src = 3'd3; e.tgt = 3'd5; e.rw = 1'b1; end
         8'hAA: begin e.src = 3'd1; e.tgt = 3'd2; e.we = 7'b0001000; end
         8'hA8: begin e.src = 3'd1; e.tgt = 3'd3; e.we = 7'b0010000; end
         8'h8A: begin e.src = 3'd2; e.tgt = 3'd1; e.we = 7'b0000100; end
         8'h98: begin e.src = 3'd3; e.tgt = 3'd1; e.we = 7'b0000100; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_we"},   32'(bus.we), 32'h0);
      chk({tag, "_rw"},   32'(bus.read_write), 32'h0);
      chk({tag, "_src0"}, 32'(bus.source_selector_0), 32'd6);
      chk({tag, "_tgt0"}, 32'(bus.target_selector_0), 32'd4);
   endtask

   task automatic chk_exec(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_src0"}, 32'(bus.source_selector_0), 32'(e.src));
         chk({tag, "_tgt0"}, 32'(bus.target_selector_0), 32'(e.tgt));
         chk({tag, "_we"},   32'(bus.we), 32'(e.we));
         chk({tag, "_rw"},   32'(bus.read_write), 32'(e.rw));
         chk({tag, "_imm"},  32'(bus.imm_addr), 32'(e.imm));
         chk({tag, "_opp"},  32'(bus.opp), 32'(e.opp));
         chk({tag, "_src1"}, 32'(bus.source_selector_1), 32'd6);
         chk({tag, "_tgt1"}, 32'(bus.target_selector_1), 32'd4);
         chk({tag, "_gn"},   32'(bus.get_next), 32'h0);
      end
   endtask

   // Entered on the falling edge of a REQ_OP cycle; returns at the next one.
   task automatic run_instr(input string tag, input logic [7:0] op,
                            input logic [7:0] arg, input int wait_op);
      logic two;
      two = is_two(op);
      chk({tag, "_gn_req"}, 32'(bus.get_next), 32'h1);
      @(negedge clk);
      for (int i = 0; i < wait_op; i++) begin
         chk({tag, "_gn_wait"}, 32'(bus.get_next), 32'h0);
         @(negedge clk);
      end
      chk({tag, "_gn_wop"}, 32'(bus.get_next), 32'h0);
      if (two) m_imm = arg;
      sb.push_back(model(op, m_imm));
      bus.instruction_in = op;
      bus.instruction_ready = 1'b1;
      @(negedge clk);
      bus.instruction_ready = 1'b0;
      if (two) begin
         chk({tag, "_gn_rarg"}, 32'(bus.get_next), 32'h1);
         chk({tag, "_opp_lat"}, 32'(bus.opp), 32'(op));
         chk_idle({tag, "_rarg"});
         bus.instruction_in = ~arg;
         bus.instruction_ready = 1'b1;
         @(negedge clk);
         bus.instruction_in = arg;
         @(negedge clk);
         bus.instruction_ready = 1'b0;
      end
      chk_exec(tag);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      m_imm = 8'h00;
      reset_n = 1'b0;
      bus.instruction_in = 8'h00;
      bus.instruction_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gn", 32'(bus.get_next), 32'h0);
      chk("rst_opp", 32'(bus.opp), 32'h0);
      chk("rst_imm", 32'(bus.imm_addr), 32'h0);
      chk_idle("rst");
      chk("rst_src1", 32'(bus.source_selector_1), 32'd6);
      chk("rst_tgt1", 32'(bus.target_selector_1), 32'd4);
      reset_n = 1'b1;
      @(negedge clk);

      run_instr("lda_imm", 8'hA9, 8'h04, 0);
      run_instr("sta_zpg", 8'h85, 8'h02, 0);
      run_instr("tax",     8'hAA, 8'h00, 0);
      run_instr("nop00",   8'h00, 8'h00, 0);
      run_instr("nopff",   8'hFF, 8'h00, 2);
      run_instr("ldx_imm", 8'hA2, 8'h33, 1);
      run_instr("ldy_imm", 8'hA0, 8'h44, 0);
      run_instr("lda_zpg", 8'hA5, 8'h10, 0);
      run_instr("stx_zpg", 8'h86, 8'h55, 0);
      run_instr("sty_zpg", 8'h84, 8'h66, 0);
      run_instr("tay",     8'hA8, 8'h00, 0);
      run_instr("txa",     8'h8A, 8'h00, 0);
      run_instr("tya",     8'h98, 8'h00, 0);
      run_instr("nopea",   8'hEA, 8'h00, 0);

      // Abort a two-byte instruction while stalled on its operand.
      chk("abt_gn_req", 32'(bus.get_next), 32'h1);
      @(negedge clk);
      bus.instruction_in = 8'hA9;
      bus.instruction_ready = 1'b1;
      @(negedge clk);
      bus.instruction_ready = 1'b0;
      chk("abt_opp", 32'(bus.opp), 32'hA9);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("abt_gn_wait", 32'(bus.get_next), 32'h0);
         chk_idle("abt_wait");
         @(negedge clk);
      end
      reset_n = 1'b0;
      @(negedge clk);
      chk("abt_rst_gn", 32'(bus.get_next), 32'h0);
      chk("abt_rst_opp", 32'(bus.opp), 32'h0);
      chk("abt_rst_imm", 32'(bus.imm_addr), 32'h0);
      chk_idle("abt_rst");
      reset_n = 1'b1;
      m_imm = 8'h00;
      @(negedge clk);
      chk_idle("abt_rel");
      run_instr("post_tay", 8'hA8, 8'h00, 0);
      chk("final_gn", 32'(bus.get_next), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
